// File: rtl/hex_byte_entry_pkg.sv
// Shared definitions for the front-panel byte entry block: FSM states,
// default debounce length and the nibble increment helper.
package hex_byte_entry_pkg;

  // 10 ms at 25 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Hex digit increment, wraps F -> 0 with no carry out
  function automatic logic [3:0] nibble_inc(input logic [3:0] nib);
    return nib + 4'd1;
  endfunction

endpackage

// File: rtl/hex_byte_entry_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press strobe on the accepted 0->1 change of the level.
module button_debounce
  import hex_byte_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             settle;

  assign differ = (sync_b != level);
  // The level flips on the edge that follows this cycle
  assign settle = differ && (cnt == CNT_LAST);

  // Strobe coincides with the edge that raises the debounced level, so
  // consumers update on that same edge (latency 2 + DEBOUNCE_CYCLES).
  assign o_press = settle && sync_b;
  assign o_level = level;

  // Bring the raw button into the clock domain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= i_btn;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has been stable long enough
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (settle) begin
      level <= sync_b;
      cnt   <= '0;
    end else if (differ) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/hex_byte_entry.sv
// Front-panel byte entry: three debounced buttons edit a byte one hex
// nibble at a time and hand it to the UART over valid/ready.
module hex_byte_entry
  import hex_byte_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_hi,
  input  logic       i_btn_lo,
  input  logic       i_btn_send,
  output logic [7:0] o_edit_byte,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy
);

  // Button index: 0 = hi nibble, 1 = lo nibble, 2 = send
  logic [2:0] btn_raw;
  logic [2:0] press;
  state_t     state;

  assign btn_raw = {i_btn_send, i_btn_lo, i_btn_hi};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn  (btn_raw[gi]),
        .o_level(),
        .o_press(press[gi])
      );
    end
  endgenerate

  // Nibble counters; both may step in the same cycle, in any FSM state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_edit_byte <= 8'h00;
    end else begin
      if (press[0]) o_edit_byte[7:4] <= nibble_inc(o_edit_byte[7:4]);
      if (press[1]) o_edit_byte[3:0] <= nibble_inc(o_edit_byte[3:0]);
    end
  end

  // Send FSM: capture the pre-edit byte, hold it until the UART takes it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      o_tx_data  <= 8'h00;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press[2]) begin
            o_tx_data  <= o_edit_byte;
            o_tx_valid <= 1'b1;
            o_busy     <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Further send presses are dropped here, not queued
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_byte_entry.sv
// Directed bench for hex_byte_entry with a short debounce length.
module tb_hex_byte_entry;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_hi = 1'b0;
  logic       btn_lo = 1'b0;
  logic       btn_send = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] edit_byte;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  hex_byte_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn_hi   (btn_hi),
    .i_btn_lo   (btn_lo),
    .i_btn_send (btn_send),
    .o_edit_byte(edit_byte),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_busy     (busy)
  );

  typedef struct {
    string      name;
    logic       hi;
    logic       lo;
    logic       send;
    logic       ready;
    int         hold;
    logic [7:0] exp_edit;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[20];

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %-14s got %02h", name, act);
    end else begin
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] e_edit, input logic e_valid,
                           input logic [7:0] e_data, input logic e_busy);
    check({name, ".edit"}, edit_byte, e_edit);
    check({name, ".valid"}, {7'd0, tx_valid}, {7'd0, e_valid});
    check({name, ".data"}, tx_data, e_data);
    check({name, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
  endtask

  // One debounced press of the given buttons, then a full release settle
  task automatic press(input logic hi, input logic lo, input logic send, input int hold);
    btn_hi = hi; btn_lo = lo; btn_send = send;
    step(hold);
    btn_hi = 1'b0; btn_lo = 1'b0; btn_send = 1'b0;
    step(2 * DB);
  endtask

  task automatic run_vec(input int i);
    tx_ready = vecs[i].ready;
    press(vecs[i].hi, vecs[i].lo, vecs[i].send, vecs[i].hold);
    check_all(vecs[i].name, vecs[i].exp_edit, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_busy);
    tx_ready = 1'b0;
  endtask

  initial begin
    //          name         hi    lo    snd   rdy   hold edit   v     data   busy
    vecs[0]  = '{"lo_glitch", 1'b0, 1'b1, 1'b0, 1'b0, 3,  8'h11, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{"hi_glitch", 1'b1, 1'b0, 1'b0, 1'b0, 2,  8'h11, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{"both_22",   1'b1, 1'b1, 1'b0, 1'b0, 8,  8'h22, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{"both_33",   1'b1, 1'b1, 1'b0, 1'b0, 8,  8'h33, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{"both_44",   1'b1, 1'b1, 1'b0, 1'b0, 8,  8'h44, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{"both_55",   1'b1, 1'b1, 1'b0, 1'b0, 8,  8'h55, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{"hi_65_rdy", 1'b1, 1'b0, 1'b0, 1'b1, 8,  8'h65, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{"hi_75",     1'b1, 1'b0, 1'b0, 1'b0, 8,  8'h75, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{"hi_85",     1'b1, 1'b0, 1'b0, 1'b0, 8,  8'h85, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{"hi_95",     1'b1, 1'b0, 1'b0, 1'b0, 8,  8'h95, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{"hi_a5",     1'b1, 1'b0, 1'b0, 1'b0, 8,  8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{"send_a5",   1'b0, 1'b0, 1'b1, 1'b0, 8,  8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[12] = '{"hi_in_send",1'b1, 1'b0, 1'b0, 1'b0, 8,  8'hB5, 1'b1, 8'hA5, 1'b1};
    vecs[13] = '{"send_again",1'b0, 1'b0, 1'b1, 1'b0, 8,  8'hB5, 1'b1, 8'hA5, 1'b1};
    vecs[14] = '{"hi_c5",     1'b1, 1'b0, 1'b0, 1'b0, 8,  8'hC5, 1'b0, 8'hA5, 1'b0};
    vecs[15] = '{"hi_d5",     1'b1, 1'b0, 1'b0, 1'b0, 8,  8'hD5, 1'b0, 8'hA5, 1'b0};
    vecs[16] = '{"hi_e5",     1'b1, 1'b0, 1'b0, 1'b0, 8,  8'hE5, 1'b0, 8'hA5, 1'b0};
    vecs[17] = '{"hi_f5",     1'b1, 1'b0, 1'b0, 1'b0, 8,  8'hF5, 1'b0, 8'hA5, 1'b0};
    vecs[18] = '{"hi_wrap_05",1'b1, 1'b0, 1'b0, 1'b0, 8,  8'h05, 1'b0, 8'hA5, 1'b0};
    vecs[19] = '{"send_05",   1'b0, 1'b0, 1'b1, 1'b0, 8,  8'h05, 1'b1, 8'h05, 1'b1};

    // Reset state, both during and after reset
    step(3);
    check_all("in_reset", 8'h00, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    step(2);
    check_all("post_reset", 8'h00, 1'b0, 8'h00, 1'b0);

    // Exact press latency: byte changes on the 6th edge after the raw rise
    btn_hi = 1'b1;
    step(DB + 1);
    check("lat_before", edit_byte, 8'h00);
    step(1);
    check("lat_at", edit_byte, 8'h10);
    step(4);
    btn_hi = 1'b0;
    step(10);
    check("release", edit_byte, 8'h10);

    // Lower nibble wraps with no carry into the upper nibble
    for (int i = 1; i <= 17; i++) begin
      press(1'b0, 1'b1, 1'b0, 8);
      if (i == 15) check("lo_15", edit_byte, 8'h1F);
      if (i == 16) check("lo_16", edit_byte, 8'h10);
      if (i == 17) check("lo_17", edit_byte, 8'h11);
    end

    for (int i = 0; i <= 13; i++) run_vec(i);

    // Transmitter stalls: offer must stay put
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("stall", {tx_valid, busy, 6'd0}, {1'b1, 1'b1, 6'd0});
      check("stall_data", tx_data, 8'hA5);
    end
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    check_all("handshake", 8'hB5, 1'b0, 8'hA5, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("no_resend", {7'd0, tx_valid}, 8'h00);
    end

    for (int i = 14; i <= 19; i++) run_vec(i);

    // Asynchronous reset while a byte is on offer
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 1'b0, 8'h00, 1'b0);
    step(2);

    // Button held across reset release gives exactly one event
    btn_hi = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(DB + 6);
    check("held_rst", edit_byte, 8'h10);
    step(10);
    check("held_once", edit_byte, 8'h10);
    btn_hi = 1'b0;
    step(10);
    check("held_release", edit_byte, 8'h10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
